// File: rtl/ddr3_ps_ctrl.sv
// ddr3_ps_ctrl: drives the fine-phase-shift port of the DDR3 clock MMCM.
// Software step commands are turned into single PSEN pulses. Each pulse waits
// for its PSDONE before the next one is issued. The controller tracks the
// signed phase position, refuses steps beyond +/-MAX_POS, and flags a missing
// PSDONE.
//
// Ports
//   clk          phase-shift clock, also the MMCM PSCLK
//   rst          asynchronous active-high reset
//   mmcm_locked  MMCM LOCKED; losing lock aborts and zeroes the position
//   cmd_valid    command request; accepted when cmd_valid && cmd_ready
//   cmd_ready    high in IDLE while the MMCM is locked
//   cmd_home     step back to position 0 (cmd_incdec/cmd_steps ignored)
//   cmd_incdec   1 = increment, 0 = decrement
//   cmd_steps    number of steps
//   err_clr      clears both sticky errors
//   PSEN         phase-shift enable to the MMCM
//   PSINCDEC     phase-shift direction to the MMCM
//   PSDONE       phase-shift acknowledge from the MMCM
//   busy         command in progress
//   done         one-cycle pulse when a command completes or aborts
//   err_timeout  sticky, PSDONE did not arrive within TIMEOUT cycles
//   err_limit    sticky, a step was refused at +/-MAX_POS
//   phase_pos    signed current position in fine-phase steps
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready follows mmcm_locked
// ISSUE | limit check, then one PSEN pulse
// WAIT  | waiting for PSDONE, timeout counter running
// GAP   | one quiet cycle so PSEN never follows PSDONE directly
// DONE  | one-cycle done pulse, then back to IDLE
module ddr3_ps_ctrl #(
  parameter int STEP_W  = 10,
  parameter int POS_W   = 12,
  parameter int MAX_POS = 168,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mmcm_locked,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_home,
  input  logic                    cmd_incdec,
  input  logic [STEP_W-1:0]       cmd_steps,
  input  logic                    err_clr,
  output logic                    PSEN,
  output logic                    PSINCDEC,
  input  logic                    PSDONE,
  output logic                    busy,
  output logic                    done,
  output logic                    err_timeout,
  output logic                    err_limit,
  output logic signed [POS_W-1:0] phase_pos
);

  // The remaining-step counter must also hold |phase_pos| for a home command.
  localparam int REM_W = (STEP_W > POS_W) ? STEP_W : POS_W;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic signed [POS_W-1:0] POS_HI  = POS_W'(MAX_POS);
  localparam logic signed [POS_W-1:0] POS_LO  = -POS_HI;
  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               dir;
  logic [REM_W-1:0]   remaining;
  logic [TMR_W-1:0]   tmr;

  logic               accept;
  logic               pos_positive;
  logic [POS_W-1:0]   pos_abs;
  logic               dir_init;
  logic [REM_W-1:0]   rem_init;
  logic               at_limit;
  logic               set_limit;
  logic               set_timeout;
  logic               ps_ack;

  assign cmd_ready    = (state == S_IDLE) && mmcm_locked;
  assign accept       = cmd_valid && cmd_ready;
  assign pos_positive = !phase_pos[POS_W-1] && (phase_pos != '0);
  assign pos_abs      = phase_pos[POS_W-1] ? $unsigned(-phase_pos) : $unsigned(phase_pos);

  // A home command walks towards zero: down from positive, up otherwise.
  assign dir_init = cmd_home ? !pos_positive : cmd_incdec;
  assign rem_init = cmd_home ? REM_W'(pos_abs) : REM_W'(cmd_steps);

  assign at_limit    = dir ? (phase_pos == POS_HI) : (phase_pos == POS_LO);
  assign ps_ack      = (state == S_WAIT) && PSDONE;
  assign set_limit   = mmcm_locked && (state == S_ISSUE) && at_limit;
  assign set_timeout = mmcm_locked && (state == S_WAIT) && !PSDONE && (tmr == '0);
  assign PSINCDEC    = dir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    PSEN      = 1'b0;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (rem_init == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (at_limit) begin
          state_nxt = S_DONE;
        end else begin
          PSEN      = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (PSDONE) begin
          state_nxt = S_GAP;
        end else if (tmr == '0) begin
          state_nxt = S_DONE;
        end
      end
      S_GAP: begin
        state_nxt = (remaining != '0) ? S_ISSUE : S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // Losing lock resets the MMCM, so any command in flight is abandoned.
    if (!mmcm_locked) begin
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir         <= 1'b0;
      remaining   <= '0;
      tmr         <= '0;
      phase_pos   <= '0;
      err_limit   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (!mmcm_locked) begin
        // MMCM reset restores zero phase.
        phase_pos <= '0;
      end else begin
        if (accept) begin
          dir       <= dir_init;
          remaining <= rem_init;
        end
        if (state == S_ISSUE) begin
          tmr <= TMR_W'(TIMEOUT - 1);
        end else if ((state == S_WAIT) && (tmr != '0)) begin
          tmr <= tmr - TMR_W'(1);
        end
        if (ps_ack) begin
          phase_pos <= dir ? (phase_pos + POS_ONE) : (phase_pos - POS_ONE);
          remaining <= remaining - REM_W'(1);
        end
        if (set_limit) begin
          remaining <= '0;
        end
      end
      // A set in the same cycle as err_clr wins.
      err_limit   <= set_limit   || (err_limit   && !err_clr);
      err_timeout <= set_timeout || (err_timeout && !err_clr);
    end
  end

endmodule

// File: tb/tb_ddr3_ps_ctrl.sv
module tb_ddr3_ps_ctrl;

  localparam int LAT = 12;

  logic               clk = 1'b0;
  logic               rst;
  logic               mmcm_locked;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_home;
  logic               cmd_incdec;
  logic [9:0]         cmd_steps;
  logic               err_clr;
  logic               PSEN;
  logic               PSINCDEC;
  logic               PSDONE;
  logic               busy;
  logic               done;
  logic               err_timeout;
  logic               err_limit;
  logic signed [11:0] phase_pos;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // MMCM model / scoreboard state
  int done_at = -1;
  bit withhold = 0;
  bit spur = 0;
  bit sb_en = 1;
  bit exp_dir = 1;
  int psen_cnt = 0;
  int psen_q[$];
  int sb_q[$];
  int model_pos = 0;
  logic signed [11:0] prev_pos = '0;

  ddr3_ps_ctrl #(
    .STEP_W(10), .POS_W(12), .MAX_POS(168), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .mmcm_locked(mmcm_locked),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_home(cmd_home),
    .cmd_incdec(cmd_incdec), .cmd_steps(cmd_steps), .err_clr(err_clr),
    .PSEN(PSEN), .PSINCDEC(PSINCDEC), .PSDONE(PSDONE),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_limit(err_limit),
    .phase_pos(phase_pos)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // MMCM model: answers each PSEN with PSDONE LAT cycles later and keeps the
  // scoreboard of expected positions; every position change pops one entry.
  initial begin
    int e;
    PSDONE = 1'b0;
    forever begin
      @(negedge clk);
      if (sb_en && (phase_pos !== prev_pos)) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: phase_pos=%0d with no step pending", phase_pos);
        end else begin
          e = sb_q.pop_front();
          if ($signed(phase_pos) != e) begin
            errors++;
            $display("FAIL sb_pos: phase_pos=%0d expected %0d", phase_pos, e);
          end
        end
      end
      prev_pos = phase_pos;
      if (PSEN === 1'b1) begin
        psen_cnt++;
        psen_q.push_back(cyc);
        checks++;
        if (PSINCDEC !== exp_dir) begin
          errors++;
          $display("FAIL psincdec: got %0b expected %0b at cycle %0d", PSINCDEC, exp_dir, cyc);
        end
        if (!withhold) begin
          done_at = cyc + LAT;
          if (sb_en) begin
            model_pos += exp_dir ? 1 : -1;
            sb_q.push_back(model_pos);
          end
        end
      end
      PSDONE = (cyc == done_at) || spur;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic h, input logic id, input int st, output int acc);
    @(negedge clk);
    acc        = cyc;
    cmd_valid  = 1'b1;
    cmd_home   = h;
    cmd_incdec = id;
    cmd_steps  = 10'(st);
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mmcm_locked = 1'b0; cmd_valid = 1'b0; cmd_home = 1'b0;
    cmd_incdec = 1'b0; cmd_steps = '0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({PSEN, PSINCDEC, busy, done, err_timeout, err_limit, cmd_ready} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000000", {PSEN, PSINCDEC, busy, done, err_timeout, err_limit, cmd_ready});
    end
    checks++;
    if (phase_pos !== 12'sd0) begin errors++; $display("FAIL reset_pos: got %0d expected 0", phase_pos); end
    rst = 1'b0;
    mmcm_locked = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_inc3();
    int a, dcyc, got;
    bit seen = 0;
    psen_q.delete(); psen_cnt = 0; exp_dir = 1;
    send_cmd(1'b0, 1'b1, 3, a);
    @(negedge clk);
    checks++;
    if ({busy, cmd_ready} !== 2'b10) begin errors++; $display("FAIL inc3_busy: busy,ready=%b expected 10", {busy, cmd_ready}); end
    for (int i = 0; i < 300; i++) begin
      if (done === 1'b1) begin seen = 1; dcyc = cyc; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL inc3_done_timeout: no done within 300 cycles"); end
    checks++;
    if (psen_cnt != 3) begin errors++; $display("FAIL inc3_psen_count: got %0d expected 3", psen_cnt); end
    for (int k = 0; k < 3; k++) begin
      got = (k < psen_q.size()) ? psen_q[k] : -1;
      checks++;
      if (got != a + 1 + 14 * k) begin errors++; $display("FAIL inc3_psen_cycle%0d: got %0d expected %0d", k, got, a + 1 + 14 * k); end
    end
    checks++;
    if (dcyc != a + 43) begin errors++; $display("FAIL inc3_done_cycle: got %0d expected %0d", dcyc, a + 43); end
    checks++;
    if (phase_pos !== 12'sd3) begin errors++; $display("FAIL inc3_pos: got %0d expected 3", phase_pos); end
    checks++;
    if ({err_timeout, err_limit} !== 2'b00) begin errors++; $display("FAIL inc3_errs: got %b expected 00", {err_timeout, err_limit}); end
    @(negedge clk);
    checks++;
    if ({done, busy, cmd_ready} !== 3'b001) begin errors++; $display("FAIL inc3_after: done,busy,ready=%b expected 001", {done, busy, cmd_ready}); end
  endtask

  task automatic test_home();
    int a, dcyc;
    bit seen = 0;
    psen_q.delete(); psen_cnt = 0; exp_dir = 0;
    send_cmd(1'b1, 1'b1, 7, a);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1; dcyc = cyc; break; end
    end
    checks++;
    if (!seen || dcyc != a + 43) begin errors++; $display("FAIL home_done_cycle: got %0d expected %0d", seen ? dcyc : -1, a + 43); end
    checks++;
    if (psen_cnt != 3) begin errors++; $display("FAIL home_psen_count: got %0d expected 3", psen_cnt); end
    checks++;
    if (phase_pos !== 12'sd0) begin errors++; $display("FAIL home_pos: got %0d expected 0", phase_pos); end
    // Home from zero: nothing to do, done right away.
    seen = 0; psen_cnt = 0;
    send_cmd(1'b1, 1'b0, 5, a);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1; dcyc = cyc; break; end
    end
    checks++;
    if (!seen || dcyc != a + 1) begin errors++; $display("FAIL home0_done_cycle: got %0d expected %0d", seen ? dcyc : -1, a + 1); end
    repeat (3) @(negedge clk);
    checks++;
    if (psen_cnt != 0) begin errors++; $display("FAIL home0_psen: got %0d pulses expected 0", psen_cnt); end
  endtask

  task automatic test_limit();
    int a, dcyc;
    bit seen = 0;
    psen_q.delete(); psen_cnt = 0; exp_dir = 1;
    send_cmd(1'b0, 1'b1, 200, a);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1; dcyc = cyc; break; end
    end
    checks++;
    if (!seen || dcyc != a + 2354) begin errors++; $display("FAIL limit_done_cycle: got %0d expected %0d", seen ? dcyc : -1, a + 2354); end
    checks++;
    if (psen_cnt != 168) begin errors++; $display("FAIL limit_psen_count: got %0d expected 168", psen_cnt); end
    checks++;
    if (phase_pos !== 12'sd168) begin errors++; $display("FAIL limit_pos: got %0d expected 168", phase_pos); end
    checks++;
    if ({err_timeout, err_limit} !== 2'b01) begin errors++; $display("FAIL limit_errs: got %b expected 01", {err_timeout, err_limit}); end
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err_limit !== 1'b0) begin errors++; $display("FAIL limit_clr: err_limit=%b expected 0", err_limit); end
  endtask

  task automatic test_timeout();
    int a, dcyc, got;
    bit seen = 0;
    psen_q.delete(); psen_cnt = 0; exp_dir = 0; withhold = 1;
    send_cmd(1'b0, 1'b0, 1, a);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1; dcyc = cyc; break; end
    end
    withhold = 0;
    got = (psen_q.size() > 0) ? psen_q[0] : -1;
    checks++;
    if (psen_cnt != 1 || got != a + 1) begin errors++; $display("FAIL tmo_psen: count %0d first %0d expected 1 at %0d", psen_cnt, got, a + 1); end
    checks++;
    if (!seen || dcyc != a + 66) begin errors++; $display("FAIL tmo_done_cycle: got %0d expected %0d", seen ? dcyc : -1, a + 66); end
    checks++;
    if ({err_timeout, err_limit} !== 2'b10) begin errors++; $display("FAIL tmo_errs: got %b expected 10", {err_timeout, err_limit}); end
    checks++;
    if (phase_pos !== 12'sd168) begin errors++; $display("FAIL tmo_pos: got %0d expected 168", phase_pos); end
    // Spurious PSDONE while idle must be ignored.
    spur = 1;
    repeat (3) @(negedge clk);
    spur = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (phase_pos !== 12'sd168 || busy !== 1'b0) begin errors++; $display("FAIL spurious_psdone: pos=%0d busy=%b expected 168 0", phase_pos, busy); end
  endtask

  task automatic test_lock_drop();
    int a;
    int done_seen = 0;
    int ready_seen = 0;
    psen_q.delete(); psen_cnt = 0; exp_dir = 0;
    send_cmd(1'b0, 1'b0, 5, a);
    for (int i = 0; i < 20 && psen_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    sb_en = 0;
    mmcm_locked = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, PSEN, done, cmd_ready} !== 4'b0000) begin errors++; $display("FAIL lock_outputs: busy,psen,done,ready=%b expected 0000", {busy, PSEN, done, cmd_ready}); end
    checks++;
    if (phase_pos !== 12'sd0) begin errors++; $display("FAIL lock_pos: got %0d expected 0", phase_pos); end
    checks++;
    if (err_timeout !== 1'b1) begin errors++; $display("FAIL lock_sticky: err_timeout=%b expected 1", err_timeout); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
      if (cmd_ready !== 1'b0) ready_seen++;
    end
    checks++;
    if (done_seen != 0 || ready_seen != 0 || phase_pos !== 12'sd0) begin
      errors++;
      $display("FAIL lock_hold: done %0d ready %0d pos %0d expected 0 0 0", done_seen, ready_seen, phase_pos);
    end
    sb_q.delete(); model_pos = 0;
    mmcm_locked = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL lock_return_ready: got %b expected 1", cmd_ready); end
    sb_en = 1;
  endtask

  task automatic test_async_reset();
    int a;
    psen_q.delete(); psen_cnt = 0; exp_dir = 1;
    send_cmd(1'b0, 1'b1, 2, a);
    for (int i = 0; i < 60 && psen_cnt < 2; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (phase_pos !== 12'sd1) begin errors++; $display("FAIL areset_pre_pos: got %0d expected 1", phase_pos); end
    sb_en = 0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({PSEN, PSINCDEC, busy, done, err_timeout, err_limit} !== 6'b0) begin
      errors++;
      $display("FAIL areset_outputs: got %b expected 000000", {PSEN, PSINCDEC, busy, done, err_timeout, err_limit});
    end
    checks++;
    if (phase_pos !== 12'sd0) begin errors++; $display("FAIL areset_pos: got %0d expected 0", phase_pos); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    sb_q.delete(); model_pos = 0;
    sb_en = 1;
  endtask

  initial begin
    test_reset();
    test_inc3();
    test_home();
    test_limit();
    test_timeout();
    test_lock_drop();
    test_async_reset();
    test_inc3();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr3_ps_ctrl.md
Name: ddr3_ps_ctrl

Overview:
- Initiator for the DDR3 clock MMCM fine-phase-shift port. Drives PSEN/PSINCDEC and consumes PSDONE.
- Accepts software step commands, either N steps up/down or "return home", and issues one MMCM shift at a time.
- Tracks the signed phase position and enforces position limits and a PSDONE timeout.
- Runs on the MMCM PSCLK domain; sits between the read-calibration register block and the DDR3 clock generator.

Parameters:
- STEP_W, 10, width of cmd_steps.
- POS_W, 12, width of signed phase_pos (two's complement).
- MAX_POS, 168, absolute position limit in fine-phase steps (one 400 MHz period at 1200 MHz VCO, 1/56 VCO step).
- TIMEOUT, 64, cycles allowed from a PSEN pulse to its PSDONE.

Ports:
- clk in 1: phase-shift clock, also the MMCM PSCLK.
- rst in 1: asynchronous, active-high reset.
- mmcm_locked in 1: MMCM LOCKED.
- cmd_valid in 1: command request.
- cmd_ready out 1: command accepted when cmd_valid && cmd_ready.
- cmd_home in 1: 1 = return phase_pos to 0; cmd_incdec and cmd_steps are ignored.
- cmd_incdec in 1: 1 = increment, 0 = decrement.
- cmd_steps in STEP_W: number of steps.
- err_clr in 1: clears sticky errors.
- PSEN out 1: to MMCM.
- PSINCDEC out 1: to MMCM.
- PSDONE in 1: from MMCM.
- busy out 1: command in progress.
- done out 1: one-cycle pulse at command completion or abort.
- err_timeout out 1: sticky; PSDONE missing.
- err_limit out 1: sticky; step refused at ±MAX_POS.
- phase_pos out POS_W: signed current position.

Behaviour:
- Reset values: PSEN=0, PSINCDEC=0, busy=0, done=0, err_timeout=0, err_limit=0, phase_pos=0. State is IDLE.
- cmd_ready = (state==IDLE) && mmcm_locked. It is combinational.
- States: IDLE, ISSUE, WAIT, GAP, DONE.
- IDLE, on accept in cycle A:
  - Latch direction and remaining count. busy=1 from A+1.
  - Home: dir = (phase_pos>0 ? dec : inc), remaining = |phase_pos|.
  - Normal: dir = cmd_incdec, remaining = cmd_steps.
  - If remaining==0, go to DONE: done=1 at A+1, no PSEN.
  - Otherwise go to ISSUE.
- ISSUE, limit check first:
  - If (inc && phase_pos==+MAX_POS) or (dec && phase_pos==-MAX_POS): set err_limit, discard remaining, go to DONE.
  - Otherwise PSEN=1 for exactly this one cycle (E), then go to WAIT.
  - PSINCDEC equals the latched dir from ISSUE through GAP and holds its value in IDLE.
- WAIT:
  - Counts cycles from E+1.
  - PSDONE in cycle P (E+1 ≤ P ≤ E+TIMEOUT): go to GAP at P+1. phase_pos changes by ±1 and remaining decrements, both visible at P+1.
  - No PSDONE by E+TIMEOUT: set err_timeout, leave phase_pos unchanged, go to DONE (done=1 at E+TIMEOUT+1).
- GAP: a single idle cycle, so PSEN is never re-asserted adjacent to PSDONE.
  - remaining>0: go to ISSUE (next PSEN at P+2).
  - Else go to DONE (done=1 at P+2).
- DONE: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- PSDONE outside WAIT is ignored and does not change phase_pos.
- mmcm_locked deasserting in any state:
  - Next cycle: state=IDLE, PSEN=0, busy=0, phase_pos=0 (MMCM reset restores zero phase). No done pulse.
  - Sticky errors are kept.
- err_clr clears both sticky errors next cycle. If err_clr coincides with an error-setting event, the set wins.
- phase_pos arithmetic: signed POS_W, never exceeds ±MAX_POS (guaranteed by the limit check). MAX_POS < 2^(POS_W-1).
- New commands are ignored while busy (cmd_ready=0).

Test Plan:
- Reset, then mmcm_locked=1, cmd inc steps=3, MMCM model returns PSDONE 12 cycles after each PSEN.
  - Expect 3 PSEN pulses at E, E+14, E+28 with PSINCDEC=1.
  - phase_pos 1,2,3; done one cycle after the final GAP; no errors.
- From phase_pos=3, cmd_home.
  - Expect 3 PSEN pulses with PSINCDEC=0; phase_pos ends at 0.
  - A second cmd_home yields done at A+1 with no PSEN.
- cmd inc steps=200 from 0.
  - Expect 168 PSEN pulses, phase_pos=168, err_limit=1, done.
  - err_clr then clears err_limit.
- Model withholds PSDONE.
  - Expect err_timeout=1 and done at E+65, phase_pos unchanged.
  - Spurious PSDONE pulses injected in IDLE do not change phase_pos.
- Drop mmcm_locked during WAIT of a 5-step command.
  - Next cycle: IDLE, phase_pos=0, busy=0, no done, cmd_ready=0 until lock returns.
- Assert rst asynchronously mid-WAIT.
  - All outputs return to reset values immediately; a following command behaves as in the first test.
